pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the LEGv8 program counter and sequences branch-target generation:
//  offset x4 (<<2), add to branch PC, select target vs PC+4.
//  Resolves B, CBZ, CBNZ, B.cond and BR from EX-stage inputs.
//  Issues a one-cycle FLUSH on taken branches and freezes on pipeline stalls.
//  Sits between decode/EX branch outputs and the instruction-fetch address port.
// PARAMETERS
//  RESET_PC    64'h0  PC value loaded on RESET
//  CNT_W       32     width of saturating taken-branch counter
// PORTS
//  CLK          in   1      clock, all state updates on rising edge
//  RESET        in   1      synchronous, active-high reset
//  STALL        in   1      hazard unit: hold PC this cycle
//  BR_VALID     in   1      EX holds a branch-class instruction this cycle
//  BR_TYPE      in   3      br_type_t: NONE/B/CBZ/CBNZ/BCOND/BR
//  BR_PC        in   64     PC of the branch in EX
//  SIGN_EXTEND  in   64     sign-extended word offset of the branch
//  REG_DATA     in   64     Rt (CBZ/CBNZ test) or Rn (BR target)
//  COND         in   4      B.cond condition field
//  FLAGS        in   4      NZCV, bit3=N
//  PC_OUT       out  64     fetch address
//  PC_VALID     out  1      PC_OUT is a fetchable address
//  FLUSH        out  1      kill IF/ID contents (wrong-path)
//  TAKEN_CNT    out  CNT_W  saturating count of taken branches
// BEHAVIOUR
//  Reset (RESET=1 at edge): PC_OUT=RESET_PC, PC_VALID=0, FLUSH=0,
//   TAKEN_CNT=0, state=RUN. First cycle after release: PC_VALID=1.
//  Target: TGT = BR_PC + (SIGN_EXTEND<<2), mod 2^64, bits shifted out lost;
//   BR uses TGT=REG_DATA unmodified. PC+4 wraps mod 2^64.
//  Taken: B,BR always; CBZ REG_DATA==0; CBNZ REG_DATA!=0; BCOND per ARM
//   table EQ..LE, AL(1110) and NV(1111) both taken; NONE never.
//  Branch acts only when BR_VALID=1 and state=RUN.
//  States:
//   RUN:   taken -> PC_OUT<=TGT, FLUSH<=1, cnt++, ->REDIR (taken beats STALL)
//          else STALL -> hold PC_OUT, ->HOLD
//          else PC_OUT<=PC_OUT+4
//   HOLD:  STALL=1 -> hold; STALL=0 -> PC_OUT+4, ->RUN. BR_VALID ignored
//          (EX frozen; branch re-presented after stall).
//   REDIR: FLUSH<=0; BR_VALID ignored (wrong-path shadow); STALL=1 -> hold
//          PC_OUT, stay REDIR; else PC_OUT<=PC_OUT+4, ->RUN.
//  FLUSH high exactly one cycle per taken branch, registered (no comb path).
//  PC_OUT, PC_VALID, FLUSH, TAKEN_CNT all registered; redirect latency 1 cycle.
//  TAKEN_CNT saturates at all-ones, never wraps.
//  RESET mid-REDIR/HOLD: reset wins, FLUSH drops same edge.
//  Unaligned TGT not checked; BR with REG_DATA[1:0]!=0 fetches as given.
// STRUCTURE
//  legv8_pkg: br_type_t enum, cond_t codes (EQ=0000..NV=1111), INSTR_SHIFT=2,
//   INSTR_BYTES=4, pcseq_state_t {RUN,HOLD,REDIR}.
//  Sub-module branch_cond_eval: combinational COND+FLAGS -> taken bit.
//  Target adder and counter inline.
// TESTING
//  Reset RESET_PC=64'h1000, no stimulus 3 cycles -> PC_OUT 1000,1004,1008,100C.
//  B at BR_PC=0x2000, SIGN_EXTEND=-4 -> next PC_OUT=0x1FF0, FLUSH=1 one cycle,
//   TAKEN_CNT=1.
//  CBZ REG_DATA=0 then CBNZ REG_DATA=0 (separate RUN cycles) -> first taken,
//   second not (PC+4, FLUSH=0).
//  B.GE FLAGS N=1,V=0 -> not taken; FLAGS N=1,V=1 -> taken; AL and NV taken.
//  STALL=1 3 cycles with BR_VALID=1 taken in HOLD -> PC frozen, no FLUSH;
//   BR_VALID in REDIR -> ignored.
//  BR_PC=64'hFFFF_FFFF_FFFF_FFFC, SIGN_EXTEND=1 -> PC_OUT=0; CNT_W=2, 4 taken
//   branches -> TAKEN_CNT=3.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 branch/PC types and constants for the PC sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package legv8_pkg;

  // Branch class presented by the EX stage
  typedef enum logic [2:0] {
    BT_NONE  = 3'd0,
    BT_B     = 3'd1,
    BT_CBZ   = 3'd2,
    BT_CBNZ  = 3'd3,
    BT_BCOND = 3'd4,
    BT_BR    = 3'd5
  } br_type_t;

  // ARM condition codes carried in the B.cond instruction
  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_t;

  // Word offsets become byte offsets by this shift; sequential fetch steps by INSTR_BYTES
  localparam int          INSTR_SHIFT = 2;
  localparam logic [63:0] INSTR_BYTES = 64'd4;

  // RUN: normal fetch; HOLD: frozen by stall; REDIR: one-cycle shadow after a taken branch
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REDIR = 2'd2
  } pcseq_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a B.cond condition field against the NZCV flags.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module branch_cond_eval
  import legv8_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,   // {N, Z, C, V}
  output logic       taken_o
);

  logic n_flag, z_flag, c_flag, v_flag;
  assign n_flag = flags_i[3];
  assign z_flag = flags_i[2];
  assign c_flag = flags_i[1];
  assign v_flag = flags_i[0];

  // Flat decode of the ARM condition table; AL and NV are both unconditional here
  always_comb begin
    taken_o = 1'b0;
    case (cond_t'(cond_i))
      C_EQ:    taken_o = z_flag;
      C_NE:    taken_o = ~z_flag;
      C_CS:    taken_o = c_flag;
      C_CC:    taken_o = ~c_flag;
      C_MI:    taken_o = n_flag;
      C_PL:    taken_o = ~n_flag;
      C_VS:    taken_o = v_flag;
      C_VC:    taken_o = ~v_flag;
      C_HI:    taken_o = c_flag & ~z_flag;
      C_LS:    taken_o = ~c_flag | z_flag;
      C_GE:    taken_o = (n_flag == v_flag);
      C_LT:    taken_o = (n_flag != v_flag);
      C_GT:    taken_o = ~z_flag & (n_flag == v_flag);
      C_LE:    taken_o = z_flag | (n_flag != v_flag);
      C_AL:    taken_o = 1'b1;
      C_NV:    taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the fetch PC: resolves EX-stage branches, redirects, flushes IF/ID, freezes on stall.
// Latency: 1 cycle from branch in EX to redirected PC_OUT and FLUSH.
// Backpressure: STALL holds PC_OUT; a taken branch in RUN overrides STALL.
module pc_sequencer
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             BR_VALID,
  input  logic [2:0]       BR_TYPE,
  input  logic [63:0]      BR_PC,
  input  logic [63:0]      SIGN_EXTEND,
  input  logic [63:0]      REG_DATA,
  input  logic [3:0]       COND,
  input  logic [3:0]       FLAGS,
  output logic [63:0]      PC_OUT,
  output logic             PC_VALID,
  output logic             FLUSH,
  output logic [CNT_W-1:0] TAKEN_CNT
);

  pcseq_state_t     state_q;
  logic [63:0]      pc_q;
  logic             pc_vld_q;
  logic             flush_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             cond_taken;
  logic             br_taken;
  logic [63:0]      br_tgt;
  logic [63:0]      pc_plus4;

  branch_cond_eval u_cond (
    .cond_i  (COND),
    .flags_i (FLAGS),
    .taken_o (cond_taken)
  );

  // BR jumps to the register as-is; all others are PC-relative with word offsets (wraps mod 2^64)
  assign br_tgt   = (br_type_t'(BR_TYPE) == BT_BR) ? REG_DATA
                                                   : BR_PC + (SIGN_EXTEND << INSTR_SHIFT);
  assign pc_plus4 = pc_q + INSTR_BYTES;
  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Per-class taken decision; unknown encodings never branch
  always_comb begin
    br_taken = 1'b0;
    case (br_type_t'(BR_TYPE))
      BT_B:     br_taken = 1'b1;
      BT_BR:    br_taken = 1'b1;
      BT_CBZ:   br_taken = (REG_DATA == 64'd0);
      BT_CBNZ:  br_taken = (REG_DATA != 64'd0);
      BT_BCOND: br_taken = cond_taken;
      default:  br_taken = 1'b0;
    endcase
  end

  // Sequencer FSM with registered PC, valid, flush and taken counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      pc_vld_q <= 1'b0;
      flush_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pc_vld_q <= 1'b1;
      flush_q  <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (BR_VALID && br_taken) begin
            pc_q    <= br_tgt;
            flush_q <= 1'b1;
            cnt_q   <= cnt_d;
            state_q <= ST_REDIR;
          end else if (STALL) begin
            state_q <= ST_HOLD;
          end else begin
            pc_q <= pc_plus4;
          end
        end
        // EX is frozen (HOLD) or on the wrong path (REDIR): branches are not looked at
        ST_HOLD, ST_REDIR: begin
          if (!STALL) begin
            pc_q    <= pc_plus4;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign PC_OUT    = pc_q;
  assign PC_VALID  = pc_vld_q;
  assign FLUSH     = flush_q;
  assign TAKEN_CNT = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a behavioural model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: STALL driven directly from stimulus.
module tb_pc_sequencer;

  localparam logic [63:0] RPC = 64'h1000;

  logic        CLK = 1'b0;
  logic        RESET, STALL, BR_VALID;
  logic [2:0]  BR_TYPE;
  logic [63:0] BR_PC, SIGN_EXTEND, REG_DATA;
  logic [3:0]  COND, FLAGS;
  logic [63:0] PC_OUT, PC_OUT2;
  logic        PC_VALID, PC_VALID2, FLUSH, FLUSH2;
  logic [31:0] TAKEN_CNT;
  logic [1:0]  TAKEN_CNT2;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [63:0] m_pc;
  logic        m_vld, m_flush;
  logic [31:0] m_cnt;
  logic [1:0]  m_cnt2;
  bit          m_frozen;   // stalled before a branch could be accepted
  bit          m_shadow;   // wrong-path cycle(s) right after a redirect

  always #5 CLK = ~CLK;

  pc_sequencer #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BR_VALID(BR_VALID), .BR_TYPE(BR_TYPE),
    .BR_PC(BR_PC), .SIGN_EXTEND(SIGN_EXTEND), .REG_DATA(REG_DATA), .COND(COND),
    .FLAGS(FLAGS), .PC_OUT(PC_OUT), .PC_VALID(PC_VALID), .FLUSH(FLUSH), .TAKEN_CNT(TAKEN_CNT)
  );

  pc_sequencer #(.RESET_PC(RPC), .CNT_W(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BR_VALID(BR_VALID), .BR_TYPE(BR_TYPE),
    .BR_PC(BR_PC), .SIGN_EXTEND(SIGN_EXTEND), .REG_DATA(REG_DATA), .COND(COND),
    .FLAGS(FLAGS), .PC_OUT(PC_OUT2), .PC_VALID(PC_VALID2), .FLUSH(FLUSH2), .TAKEN_CNT(TAKEN_CNT2)
  );

  // ARM condition semantics: base test on c[3:1], odd codes invert (except 1111)
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    logic [2:0] base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = c[3:1];
    case (base)
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c != 4'hF) r = !r;
    return r;
  endfunction

  function automatic bit model_taken();
    case (BR_TYPE)
      3'd1, 3'd5: return 1'b1;
      3'd2:       return REG_DATA == 64'd0;
      3'd3:       return REG_DATA != 64'd0;
      3'd4:       return cond_holds(COND, FLAGS);
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    if (RESET) begin
      m_pc = RPC; m_vld = 1'b0; m_flush = 1'b0; m_cnt = '0; m_cnt2 = '0;
      m_frozen = 1'b0; m_shadow = 1'b0;
    end else begin
      m_vld   = 1'b1;
      m_flush = 1'b0;
      if (!m_frozen && !m_shadow && BR_VALID && model_taken()) begin
        m_pc     = (BR_TYPE == 3'd5) ? REG_DATA : BR_PC + SIGN_EXTEND * 64'd4;
        m_flush  = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 1;
        m_shadow = 1'b1;
      end else if (STALL) begin
        if (!m_shadow) m_frozen = 1'b1;
      end else begin
        m_pc     = m_pc + 64'd4;
        m_frozen = 1'b0;
        m_shadow = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle(input bit rst, input bit stl, input bit brv, input logic [2:0] bt,
                          input logic [63:0] bpc, input logic [63:0] se, input logic [63:0] rd,
                          input logic [3:0] cnd, input logic [3:0] flg);
    RESET = rst; STALL = stl; BR_VALID = brv; BR_TYPE = bt; BR_PC = bpc;
    SIGN_EXTEND = se; REG_DATA = rd; COND = cnd; FLAGS = flg;
    @(posedge CLK);
    model_step();
    #1;
    chk("pc_out",    PC_OUT,             m_pc);
    chk("pc_valid",  64'(PC_VALID),      64'(m_vld));
    chk("flush",     64'(FLUSH),         64'(m_flush));
    chk("taken_cnt", 64'(TAKEN_CNT),     64'(m_cnt));
    chk("pc_out_w2", PC_OUT2,            m_pc);
    chk("cnt_w2",    64'(TAKEN_CNT2),    64'(m_cnt2));
  endtask

  task automatic idle(input bit stl);
    do_cycle(1'b0, stl, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 4'h0, 4'h0);
  endtask

  task automatic branch(input bit stl, input logic [2:0] bt, input logic [63:0] bpc,
                        input logic [63:0] se, input logic [63:0] rd,
                        input logic [3:0] cnd, input logic [3:0] flg);
    do_cycle(1'b0, stl, 1'b1, bt, bpc, se, rd, cnd, flg);
  endtask

  initial begin
    logic [63:0] frz;
    logic [31:0] r;
    do_cycle(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 4'h0, 4'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 4'h0, 4'h0);
    chk("rst_pc",    PC_OUT, 64'h1000);
    chk("rst_valid", 64'(PC_VALID), 64'd0);
    chk("rst_flush", 64'(FLUSH), 64'd0);
    chk("rst_cnt",   64'(TAKEN_CNT), 64'd0);

    idle(1'b0); chk("seq_1004", PC_OUT, 64'h1004); chk("valid_up", 64'(PC_VALID), 64'd1);
    idle(1'b0); chk("seq_1008", PC_OUT, 64'h1008);
    idle(1'b0); chk("seq_100c", PC_OUT, 64'h100C);

    // B with negative offset
    branch(1'b0, 3'd1, 64'h2000, -64'sd4, 64'd0, 4'h0, 4'h0);
    chk("b_tgt", PC_OUT, 64'h1FF0); chk("b_flush", 64'(FLUSH), 64'd1);
    chk("b_cnt", 64'(TAKEN_CNT), 64'd1);
    idle(1'b0); chk("b_flush_drop", 64'(FLUSH), 64'd0); chk("b_after", PC_OUT, 64'h1FF4);

    // CBZ taken, then CBNZ with zero not taken
    branch(1'b0, 3'd2, 64'h3000, 64'd8, 64'd0, 4'h0, 4'h0);
    chk("cbz_tgt", PC_OUT, 64'h3020);
    idle(1'b0);
    frz = PC_OUT;
    branch(1'b0, 3'd3, 64'h4000, 64'd8, 64'd0, 4'h0, 4'h0);
    chk("cbnz_nt_pc", PC_OUT, frz + 64'd4); chk("cbnz_nt_flush", 64'(FLUSH), 64'd0);

    // B.GE, AL, NV
    frz = PC_OUT;
    branch(1'b0, 3'd4, 64'h5000, 64'd1, 64'd0, 4'hA, 4'b1000);
    chk("bge_nt", PC_OUT, frz + 64'd4);
    branch(1'b0, 3'd4, 64'h5000, 64'd1, 64'd0, 4'hA, 4'b1001);
    chk("bge_t", PC_OUT, 64'h5004);
    idle(1'b0);
    branch(1'b0, 3'd4, 64'h6000, 64'd2, 64'd0, 4'hE, 4'b0000);
    chk("bal_t", PC_OUT, 64'h6008);
    idle(1'b0);
    branch(1'b0, 3'd4, 64'h7000, 64'd3, 64'd0, 4'hF, 4'b0000);
    chk("bnv_t", PC_OUT, 64'h700C);
    idle(1'b0);

    // Stall into HOLD, taken branches ignored while frozen
    idle(1'b1);
    frz = PC_OUT;
    for (int i = 0; i < 3; i++) begin
      branch(1'b1, 3'd1, 64'h8000, 64'd4, 64'd0, 4'h0, 4'h0);
      chk("hold_pc", PC_OUT, frz); chk("hold_flush", 64'(FLUSH), 64'd0);
    end
    branch(1'b0, 3'd1, 64'h8000, 64'd4, 64'd0, 4'h0, 4'h0);
    chk("hold_release", PC_OUT, frz + 64'd4);

    // Branch in the redirect shadow is ignored; stall in shadow holds the PC
    branch(1'b1, 3'd5, 64'd0, 64'd0, 64'h9000, 4'h0, 4'h0);
    chk("br_beats_stall", PC_OUT, 64'h9000);
    branch(1'b1, 3'd1, 64'hA000, 64'd0, 64'd0, 4'h0, 4'h0);
    chk("redir_stall_pc", PC_OUT, 64'h9000); chk("redir_flush0", 64'(FLUSH), 64'd0);
    branch(1'b0, 3'd1, 64'hA000, 64'd0, 64'd0, 4'h0, 4'h0);
    chk("redir_ignore", PC_OUT, 64'h9004);

    // Target wrap and narrow-counter saturation
    branch(1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd0, 4'h0, 4'h0);
    chk("wrap_pc", PC_OUT, 64'h0);
    chk("sat_w2", 64'(TAKEN_CNT2), 64'd3);

    // Reset during REDIR drops FLUSH on the same edge
    idle(1'b0);
    branch(1'b0, 3'd1, 64'hB000, 64'd0, 64'd0, 4'h0, 4'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 4'h0, 4'h0);
    chk("rst_redir_flush", 64'(FLUSH), 64'd0); chk("rst_redir_pc", PC_OUT, 64'h1000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      do_cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, {{44{r[19]}}, r[19:0]},
               ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom},
               4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
